// File: rtl/uw_pkg.sv
// Shared types and constants for the unique-word search/score/sync chain.
package uw_pkg;
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} sync_state_t;

  typedef logic [1:0] rot_t;
  localparam rot_t ROT_0   = 2'd0;
  localparam rot_t ROT_90  = 2'd1;
  localparam rot_t ROT_180 = 2'd2;
  localparam rot_t ROT_270 = 2'd3;

  localparam int UW_LEN       = 16;
  localparam int UW_MAX_SCORE = 32;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/uw_frame_sync_if.sv
// Score input and sync-status output bundle between the score stage and frame sync.
interface uw_frame_sync_if
  import uw_pkg::*;
#(
  parameter int SCORE_W = 6,
  parameter int POS_W   = 8
);
  logic               score_valid;
  logic [SCORE_W-1:0] score;
  rot_t               best_rot;
  logic               locked;
  rot_t               rot_out;
  logic               frame_start;
  logic [POS_W-1:0]   frame_pos;
  logic               uw_miss;
  logic               rot_change;

  modport master (
    output score_valid, score, best_rot,
    input  locked, rot_out, frame_start, frame_pos, uw_miss, rot_change
  );

  modport slave (
    input  score_valid, score, best_rot,
    output locked, rot_out, frame_start, frame_pos, uw_miss, rot_change
  );
endinterface

// File: rtl/uw_frame_sync.sv
// UW frame synchroniser: threshold scores, search/verify/lock FSM with frame flywheel.
// Optional UW_ROT_TRACK_EN: in LOCKED, follow a rotation slip instead of counting a miss.
module uw_frame_sync
  import uw_pkg::*;
#(
  parameter int FRAME_LEN   = 256,
  parameter int SCORE_W     = 6,
  parameter int THRESH      = 28,
  parameter int VERIFY_HITS = 2,
  parameter int LOSS_MISSES = 3,
  parameter int POS_W       = $clog2(FRAME_LEN)
) (
  input logic           clk,
  input logic           rst,
  uw_frame_sync_if.slave sif
);
  localparam int CNT_W = $clog2(imax(VERIFY_HITS, LOSS_MISSES) + 1);
  localparam logic [SCORE_W-1:0] THR     = SCORE_W'(THRESH);
  localparam logic [POS_W-1:0]   POS_END = POS_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]   VH_C    = CNT_W'(VERIFY_HITS);
  localparam logic [CNT_W-1:0]   LM_C    = CNT_W'(LOSS_MISSES);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  sync_state_t      state, state_n;
  logic [CNT_W-1:0] hits, hits_n, misses, misses_n;
  logic [POS_W-1:0] pos, pos_n;
  rot_t             rot, rot_n;
  logic             locked, fs, miss, rc;
  logic             fs_n, miss_n, rc_n;

  logic             hit, qhit, expected;
  logic [POS_W-1:0] pos_adv;
  logic [CNT_W-1:0] hits_inc, misses_inc;

  assign hit        = (sif.score >= THR);
  assign qhit       = hit && (sif.best_rot == rot);
  assign expected   = (pos == POS_END);
  assign pos_adv    = expected ? '0 : pos + 1'b1;
  // counters saturate rather than wrap
  assign hits_inc   = (hits == CNT_MAX) ? hits : hits + 1'b1;
  assign misses_inc = (misses == CNT_MAX) ? misses : misses + 1'b1;

  always_comb begin
    state_n  = state;
    hits_n   = hits;
    misses_n = misses;
    pos_n    = pos;
    rot_n    = rot;
    fs_n     = 1'b0;
    miss_n   = 1'b0;
    rc_n     = 1'b0;
    if (sif.score_valid) begin
      unique case (state)
        SEARCH: begin
          if (hit) begin
            rot_n    = sif.best_rot;
            pos_n    = '0;
            hits_n   = CNT_W'(1);
            misses_n = '0;
            if (VERIFY_HITS == 1) begin
              state_n = LOCKED;
              fs_n    = 1'b1;
            end else begin
              state_n = VERIFY;
            end
          end
        end
        VERIFY: begin
          pos_n = pos_adv;
          if (expected) begin
            if (qhit) begin
              hits_n = hits_inc;
              if (hits_inc >= VH_C) begin
                state_n  = LOCKED;
                fs_n     = 1'b1;
                misses_n = '0;
              end
            end else begin
              miss_n  = 1'b1;
              state_n = SEARCH;
              hits_n  = '0;
              pos_n   = '0;
            end
          end
        end
        LOCKED: begin
          pos_n = pos_adv;
          if (expected) begin
            fs_n = 1'b1;
            if (qhit) begin
              misses_n = '0;
            end
`ifdef UW_ROT_TRACK_EN
            else if (hit) begin
              rot_n    = sif.best_rot;
              rc_n     = 1'b1;
              misses_n = '0;
            end
`endif
            else begin
              miss_n   = 1'b1;
              misses_n = misses_inc;
              // frame_start still fires for the event that drops lock
              if (misses_inc >= LM_C) begin
                state_n  = SEARCH;
                pos_n    = '0;
                hits_n   = '0;
                misses_n = '0;
              end
            end
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SEARCH;
      hits   <= '0;
      misses <= '0;
      pos    <= '0;
      rot    <= ROT_0;
      locked <= 1'b0;
      fs     <= 1'b0;
      miss   <= 1'b0;
      rc     <= 1'b0;
    end else begin
      state  <= state_n;
      hits   <= hits_n;
      misses <= misses_n;
      pos    <= pos_n;
      rot    <= rot_n;
      locked <= (state_n == LOCKED);
      fs     <= fs_n;
      miss   <= miss_n;
      rc     <= rc_n;
    end
  end

  assign sif.locked      = locked;
  assign sif.rot_out     = rot;
  assign sif.frame_start = fs;
  assign sif.frame_pos   = pos;
  assign sif.uw_miss     = miss;
`ifdef UW_ROT_TRACK_EN
  assign sif.rot_change  = rc;
`else
  assign sif.rot_change  = 1'b0;
`endif
endmodule

// File: tb/tb_uw_frame_sync.sv
// Bench for uw_frame_sync: directed vector table, then random traffic vs an anchor-based model.
module tb_uw_frame_sync;
  localparam int F  = 16;
  localparam int TH = 28;
  localparam int VH = 2;
  localparam int LM = 3;
`ifdef UW_ROT_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uw_frame_sync_if #(.SCORE_W(6), .POS_W(4)) sif ();

  uw_frame_sync #(
    .FRAME_LEN(F), .SCORE_W(6), .THRESH(TH),
    .VERIFY_HITS(VH), .LOSS_MISSES(LM), .POS_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sif(sif)
  );

  int nchecks = 0;
  int nerr    = 0;

  // model: sync phase kept as the absolute index of the acquiring event
  int m_mode, m_anchor, m_evn, m_rot, m_hits, m_miss;
  int x_lock, x_fs, x_miss, x_rc, x_pos;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit rs, input bit v, input int sc, input int r);
    bit h, ex;
    x_fs = 0; x_miss = 0; x_rc = 0;
    if (rs) begin
      m_mode = 0; m_anchor = 0; m_evn = 0; m_rot = 0; m_hits = 0; m_miss = 0;
      x_lock = 0; x_pos = 0;
      return;
    end
    if (!v) return;
    h = (sc >= TH);
    if (m_mode == 0) begin
      if (h) begin
        m_anchor = m_evn; m_rot = r; m_hits = 1; m_miss = 0;
        m_mode = (VH == 1) ? 2 : 1;
        x_fs = (VH == 1);
      end
    end else begin
      ex = ((m_evn - m_anchor) % F) == 0;
      if (ex && m_mode == 1) begin
        if (h && r == m_rot) begin
          m_hits++;
          if (m_hits >= VH) begin m_mode = 2; m_miss = 0; x_fs = 1; end
        end else begin
          x_miss = 1; m_mode = 0; m_hits = 0;
        end
      end else if (ex) begin
        x_fs = 1;
        if (h && r == m_rot) m_miss = 0;
        else if (TRACK && h) begin m_rot = r; x_rc = 1; m_miss = 0; end
        else begin
          x_miss = 1; m_miss++;
          if (m_miss >= LM) begin m_mode = 0; m_hits = 0; m_miss = 0; end
        end
      end
    end
    x_pos  = (m_mode == 0) ? 0 : (m_evn - m_anchor) % F;
    x_lock = (m_mode == 2);
    m_evn++;
  endtask

  task automatic drive(input bit v, input int sc, input int r, input bit rs);
    @(negedge clk);
    sif.score_valid = v;
    sif.score       = 6'(sc);
    sif.best_rot    = 2'(r);
    rst             = rs;
    @(posedge clk);
    #1;
    model_step(rs, v, sc, r);
    chk("model locked",      32'(sif.locked),      32'(x_lock));
    chk("model rot_out",     32'(sif.rot_out),     32'(m_rot));
    chk("model frame_start", 32'(sif.frame_start), 32'(x_fs));
    chk("model frame_pos",   32'(sif.frame_pos),   32'(x_pos));
    chk("model uw_miss",     32'(sif.uw_miss),     32'(x_miss));
    chk("model rot_change",  32'(sif.rot_change),  32'(x_rc));
  endtask

  typedef struct {
    int rep; bit v; int sc; int rot; bit rs;
    int e_lock; int e_rot; int e_fs; int e_pos; int e_miss; int e_rc;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int rep, input bit v, input int sc, input int rot, input bit rs,
                              input int el, input int er, input int ef, input int ep,
                              input int em, input int ec);
    vec_t t;
    t.rep = rep; t.v = v; t.sc = sc; t.rot = rot; t.rs = rs;
    t.e_lock = el; t.e_rot = er; t.e_fs = ef; t.e_pos = ep; t.e_miss = em; t.e_rc = ec;
    tbl.push_back(t);
  endfunction

  initial begin
    int rl, sm, sc;
    sif.score_valid = 1'b0;
    sif.score       = '0;
    sif.best_rot    = '0;
    rl = TRACK ? 3 : 1;
    sm = TRACK ? 0 : 1;

    add(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);          // reset
    add(1, 1, 30, 1, 0, 0, 1, 0, 0, 0, 0);          // acquire at event 0
    add(15, 1, 10, 1, 0, 0, 1, 0, 15, 0, 0);
    add(1, 1, 30, 1, 0, 1, 1, 1, 0, 0, 0);          // event 16 -> locked
    add(7, 1, 10, 0, 0, 1, 1, 0, 7, 0, 0);
    add(5, 0, 31, 2, 0, 1, 1, 0, 7, 0, 0);          // hold mid-frame
    add(8, 1, 10, 0, 0, 1, 1, 0, 15, 0, 0);
    add(1, 1, 30, 1, 0, 1, 1, 1, 0, 0, 0);          // event 32
    add(15, 1, 10, 0, 0, 1, 1, 0, 15, 0, 0);
    add(1, 1, 5, 1, 0,  1, 1, 1, 0, 1, 0);          // miss 1
    add(15, 1, 10, 0, 0, 1, 1, 0, 15, 0, 0);
    add(1, 1, 30, 1, 0, 1, 1, 1, 0, 0, 0);          // recovery
    add(15, 1, 10, 0, 0, 1, 1, 0, 15, 0, 0);
    add(1, 1, 5, 1, 0,  1, 1, 1, 0, 1, 0);
    add(15, 1, 10, 0, 0, 1, 1, 0, 15, 0, 0);
    add(1, 1, 5, 1, 0,  1, 1, 1, 0, 1, 0);          // two misses, still locked
    add(15, 1, 10, 0, 0, 1, 1, 0, 15, 0, 0);
    add(1, 1, 30, 1, 0, 1, 1, 1, 0, 0, 0);
    add(15, 1, 10, 0, 0, 1, 1, 0, 15, 0, 0);
    add(1, 1, 32, 3, 0, 1, rl, 1, 0, sm, 1 - sm);   // rotation slip
    add(15, 1, 10, 0, 0, 1, rl, 0, 15, 0, 0);
    add(1, 1, 30, rl, 0, 1, rl, 1, 0, 0, 0);
    add(15, 1, 10, 0, 0, 1, rl, 0, 15, 0, 0);
    add(1, 1, 5, 0, 0,  1, rl, 1, 0, 1, 0);         // loss 1
    add(15, 1, 10, 0, 0, 1, rl, 0, 15, 0, 0);
    add(1, 1, 5, 0, 0,  1, rl, 1, 0, 1, 0);         // loss 2
    add(15, 1, 10, 0, 0, 1, rl, 0, 15, 0, 0);
    add(1, 1, 5, 0, 0,  0, rl, 1, 0, 1, 0);         // loss 3 drops lock
    add(3, 1, 10, 0, 0, 0, rl, 0, 0, 0, 0);
    add(1, 1, 27, 2, 0, 0, rl, 0, 0, 0, 0);         // just below threshold
    add(1, 1, 29, 2, 0, 0, 2, 0, 0, 0, 0);
    add(15, 1, 10, 0, 0, 0, 2, 0, 15, 0, 0);
    add(1, 1, 28, 2, 0, 1, 2, 1, 0, 0, 0);          // exactly threshold
    add(4, 1, 10, 0, 0, 1, 2, 0, 4, 0, 0);
    add(1, 1, 30, 2, 1, 0, 0, 0, 0, 0, 0);          // reset while locked
    add(1, 1, 30, 1, 0, 0, 1, 0, 0, 0, 0);          // false start
    add(15, 1, 10, 0, 0, 0, 1, 0, 15, 0, 0);
    add(1, 1, 20, 1, 0, 0, 1, 0, 0, 1, 0);
    add(1, 1, 30, 1, 0, 0, 1, 0, 0, 0, 0);          // wrong rotation in verify
    add(5, 1, 10, 0, 0, 0, 1, 0, 5, 0, 0);
    add(1, 1, 31, 1, 0, 0, 1, 0, 6, 0, 0);          // off-phase hit ignored
    add(9, 1, 10, 0, 0, 0, 1, 0, 15, 0, 0);
    add(1, 1, 31, 2, 0, 0, 1, 0, 0, 1, 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].rep; k++) drive(tbl[i].v, tbl[i].sc, tbl[i].rot, tbl[i].rs);
      chk($sformatf("row%0d locked", i),      32'(sif.locked),      32'(tbl[i].e_lock));
      chk($sformatf("row%0d rot_out", i),     32'(sif.rot_out),     32'(tbl[i].e_rot));
      chk($sformatf("row%0d frame_start", i), 32'(sif.frame_start), 32'(tbl[i].e_fs));
      chk($sformatf("row%0d frame_pos", i),   32'(sif.frame_pos),   32'(tbl[i].e_pos));
      chk($sformatf("row%0d uw_miss", i),     32'(sif.uw_miss),     32'(tbl[i].e_miss));
      chk($sformatf("row%0d rot_change", i),  32'(sif.rot_change),  32'(tbl[i].e_rc));
    end

    for (int n = 0; n < 4000; n++) begin
      bit rs, v, at_uw;
      int r;
      rs    = ($urandom_range(0, 599) == 0);
      v     = ($urandom_range(0, 7) != 0);
      at_uw = (m_mode != 0) && (((m_evn - m_anchor) % F) == 0);
      if (at_uw) begin
        sc = ($urandom_range(0, 9) < 8) ? $urandom_range(TH, 32) : $urandom_range(0, TH - 1);
        r  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : m_rot;
      end else begin
        sc = ($urandom_range(0, 29) == 0) ? $urandom_range(TH, 32) : $urandom_range(0, TH - 1);
        r  = $urandom_range(0, 3);
      end
      drive(v, sc, r, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule

// File: doc/uw_frame_sync.md
Name: uw_frame_sync

Overview:
- Sits directly downstream of the unique-word (UW) match-score stage.
- Consumes one score/rotation result per symbol advance and thresholds it to flag UW hits.
- Runs a search/verify/lock state machine with a frame-period flywheel.
- Outputs lock status, the locked phase rotation, a frame-start strobe and the symbol position within the frame, for the derotator and deframer.

Parameters:
- FRAME_LEN, 256: symbol events between consecutive UW occurrences (>=2)
- SCORE_W, 6: score input width (0..32 needs 6 bits; upstream score is widened to match)
- THRESH, 28: minimum score counted as a UW hit (comparison is >=)
- VERIFY_HITS, 2: consecutive periodic hits needed to enter LOCKED (>=1)
- LOSS_MISSES, 3: consecutive misses in LOCKED that drop lock (>=1)
- POS_W, $clog2(FRAME_LEN): frame_pos width

Ports:
- clk, in, 1: clock
- rst, in, 1: synchronous active-high reset
- score_valid, in, 1: one new score/best_rot pair this cycle (one per symbol advance)
- score, in, SCORE_W: match score
- best_rot, in, 2: best rotation (0/90/180/270 deg)
- locked, out, 1: high in LOCKED
- rot_out, out, 2: rotation captured at acquisition
- frame_start, out, 1: 1-cycle pulse at each expected UW position while LOCKED (hit or flywheel)
- frame_pos, out, POS_W: event index since last UW, 0..FRAME_LEN-1
- uw_miss, out, 1: 1-cycle pulse when an expected UW is missed in VERIFY or LOCKED
- rot_change, out, 1: rotation-update pulse (tied 0 unless feature enabled)

Behaviour:
- Reset: state=SEARCH, locked=0, rot_out=0, frame_start=0, frame_pos=0, uw_miss=0, rot_change=0, internal hit/miss counters=0. Reset mid-operation aborts any state; no pulse is emitted in the reset cycle.
- All outputs are registered. A response appears one clk after the score_valid cycle.
- score_valid=0: state, counters and frame_pos hold; pulses are 0.
- hit = (score >= THRESH). A rotation-qualified hit is hit && best_rot==rot_out.
- frame_pos advance on each score_valid outside SEARCH: (frame_pos==FRAME_LEN-1) ? 0 : frame_pos+1. An "expected event" is a score_valid arriving while frame_pos==FRAME_LEN-1.
- SEARCH:
  - On hit: capture rot_out<=best_rot, frame_pos<=0, hits<=1.
  - Go to VERIFY, or directly to LOCKED with frame_start pulse if VERIFY_HITS==1.
  - Otherwise stay; frame_pos stays 0.
- VERIFY:
  - Non-expected events only advance frame_pos.
  - Expected event with rotation-qualified hit: hits++. On reaching VERIFY_HITS, go to LOCKED and pulse frame_start.
  - Expected event otherwise: uw_miss pulse, go to SEARCH, hits=0, frame_pos=0.
  - Hits at non-expected positions are ignored.
- LOCKED:
  - Every expected event pulses frame_start and wraps frame_pos to 0.
  - Rotation-qualified hit: misses<=0.
  - Otherwise: uw_miss pulse, misses++. On reaching LOSS_MISSES, go to SEARCH, locked<=0 and frame_pos<=0 on the same edge; frame_start is still pulsed for that event.
  - A hit with a different rotation counts as a miss (without the feature).
- Counters saturate and never wrap. Width is clog2 of max(VERIFY_HITS, LOSS_MISSES)+1.

Optional Feature:
- Macro: UW_ROT_TRACK_EN.
- Defined: in LOCKED, an expected event with hit but best_rot!=rot_out counts as a hit. rot_out<=best_rot, rot_change pulses 1 cycle, misses<=0. VERIFY behaviour is unchanged.
- Undefined: such an event is a miss; rot_change is constant 0.

Decomposition:
- Shared package uw_pkg:
  - sync_state_t enum {SEARCH, VERIFY, LOCKED}
  - rot_t (2-bit) with ROT_0/90/180/270 constants
  - UW_LEN=16 and UW_MAX_SCORE=32, reused by the score stage
- No sub-module. The hit compare is one line; counter and FSM stay in one always block.

Test Plan (FRAME_LEN=16, THRESH=28, VERIFY_HITS=2, LOSS_MISSES=3):
- Acquisition: score=30/rot=1 at event 0, then score=30/rot=1 at events 16 and 32, all others score=10. Expect: VERIFY after event 0; locked=1, rot_out=1 and frame_start one cycle after event 16; frame_start again after event 32.
- False start: hit at event 0, score=20 at event 16. Expect: uw_miss pulse, return to SEARCH, locked stays 0.
- Flywheel/loss: after lock, three expected events with score=5. Expect: frame_start and uw_miss on each; locked drops after the third.
- Recovery: after lock, one miss then a hit. Expect: misses cleared; two further misses do not drop lock.
- Rotation slip: locked with rot=1, expected event score=32/rot=3. Expect uw_miss (macro off); with UW_ROT_TRACK_EN, rot_out=3, rot_change pulse, no uw_miss.
- Holds/reset: score_valid low for 5 cycles mid-frame leaves frame_pos unchanged. rst asserted while LOCKED gives all outputs 0 next cycle.
